rn_release_sequencer: RTL and testbench



---
 rtl/rn_release_sequencer.sv | 155 +++++++++++++++
 tb/tb_rn_release_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/rn_release_sequencer.sv
// -----------------------------------------------------------------------------
// rn_release_sequencer
//
// Sequences the active-low reset (RN) and the downstream clock enable for NGRP
// banks of negative-edge resettable flops. RN is held low for MIN_LOW cycles,
// then the selected groups are released one at a time in ascending index
// order, GAP cycles apart. After the last release the block waits GAP more
// cycles before re-enabling the gated clock. This keeps every CLKN falling
// edge out of the recovery/removal window of each RN rise.
//
// Ports:
//   CLK    in   sequencer clock, rising edge, free-running
//   RST    in   synchronous active-high reset; restarts the all-group sequence
//   REQ    in   soft-reset request pulse, honoured only while idle
//   MASK   in   groups to reset on REQ (sampled with REQ; zero is ignored)
//   RN     out  per-group active-low flop reset, registered
//   CLKEN  out  downstream clock-gate enable (0 parks CLKN high), registered
//   BUSY   out  high while a sequence is in progress, registered
//   DONE   out  one-cycle pulse as a sequence completes, registered
// -----------------------------------------------------------------------------
module rn_release_sequencer #(
  parameter int NGRP    = 4,
  parameter int MIN_LOW = 4,
  parameter int GAP     = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            REQ,
  input  logic [NGRP-1:0] MASK,
  output logic [NGRP-1:0] RN,
  output logic            CLKEN,
  output logic            BUSY,
  output logic            DONE
);

  localparam int CMAX = (MIN_LOW > GAP) ? MIN_LOW : GAP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = (NGRP > 1) ? $clog2(NGRP) : 1;

  localparam logic [CW-1:0] MIN_LOW_C = CW'(MIN_LOW);
  localparam logic [CW-1:0] GAP_C     = CW'(GAP);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NGRP - 1);

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    RELEASE,
    SETTLE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NGRP-1:0] pend_q, pend_d;   // active groups still held in reset
  logic [NGRP-1:0] rn_q, rn_d;
  logic            clken_q, clken_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Lowest-index group still waiting; skipping inactive groups costs no cycles.
  logic [IW-1:0]   idx;
  logic [NGRP-1:0] pend_rest;
  logic            last_grp;
  logic            rel_now;

  always_comb begin
    idx = '0;
    for (int i = NGRP - 1; i >= 0; i--) begin
      if (pend_q[i]) idx = IW'(i);
    end
    pend_rest      = pend_q;
    pend_rest[idx] = 1'b0;
    last_grp       = (idx == LAST_IDX) || (pend_rest == '0);
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    rn_d    = rn_q;
    clken_d = clken_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rel_now = 1'b0;

    case (state_q)
      IDLE: begin
        if (REQ && (MASK != '0)) begin
          state_d = ASSERT;
          // The request edge itself is the first of the MIN_LOW low cycles.
          cnt_d   = CW'(1);
          pend_d  = MASK;
          rn_d    = rn_q & ~MASK;
          clken_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ASSERT: begin
        if (cnt_q == MIN_LOW_C) rel_now = 1'b1;
        else                    cnt_d   = cnt_q + CW'(1);
      end
      RELEASE: begin
        if (cnt_q == GAP_C) rel_now = 1'b1;
        else                cnt_d   = cnt_q + CW'(1);
      end
      SETTLE: begin
        if (cnt_q == GAP_C) begin
          state_d = IDLE;
          cnt_d   = '0;
          clken_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ASSERT;
    endcase

    if (rel_now) begin
      rn_d[idx] = 1'b1;
      pend_d    = pend_rest;
      cnt_d     = CW'(1);
      state_d   = last_grp ? SETTLE : RELEASE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ASSERT;
      cnt_q   <= '0;
      pend_q  <= '1;
      rn_q    <= '0;
      clken_q <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      rn_q    <= rn_d;
      clken_q <= clken_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign RN    = rn_q;
  assign CLKEN = clken_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_rn_release_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rn_release_sequencer
//
// Drives directed scenarios followed by random REQ/MASK/RST traffic. The
// reference model works from release times: each sequence has a start edge,
// and a group's RN is 1 once the edge count reaches
// start + MIN_LOW + position*GAP. Completion falls at
// start + MIN_LOW + count*GAP. Outputs are compared 1 time unit after every
// rising edge, alongside the CLKEN/RN and DONE/BUSY invariants.
// -----------------------------------------------------------------------------
module tb_rn_release_sequencer;

  localparam int NGRP    = 4;
  localparam int MIN_LOW = 4;
  localparam int GAP     = 2;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            REQ = 1'b0;
  logic [NGRP-1:0] MASK = '0;
  logic [NGRP-1:0] RN;
  logic            CLKEN;
  logic            BUSY;
  logic            DONE;

  rn_release_sequencer #(
    .NGRP   (NGRP),
    .MIN_LOW(MIN_LOW),
    .GAP    (GAP)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .REQ  (REQ),
    .MASK (MASK),
    .RN   (RN),
    .CLKEN(CLKEN),
    .BUSY (BUSY),
    .DONE (DONE)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Reference model state.
  int              cyc = 0;        // index of the most recent rising edge
  bit              m_cold = 1'b0;  // next edge with RST low starts the full sequence
  bit              m_in_seq = 1'b0;
  int              m_start = 0;
  logic [NGRP-1:0] m_mask = '0;
  logic [NGRP-1:0] e_rn;
  logic            e_clken, e_busy, e_done;
  logic            prev_busy = 1'b1;
  logic            prev_done = 1'b0;

  task automatic model(input logic r, input logic q, input logic [NGRP-1:0] m);
    int j;
    int t_done;
    if (r) begin
      e_rn = '0; e_clken = 1'b0; e_busy = 1'b1; e_done = 1'b0;
      m_in_seq = 1'b0;
      m_cold   = 1'b1;
    end else begin
      if (m_cold) begin
        m_cold = 1'b0; m_in_seq = 1'b1; m_start = cyc; m_mask = '1;
      end else if (!m_in_seq && q && (m != '0)) begin
        m_in_seq = 1'b1; m_start = cyc; m_mask = m;
      end
      if (m_in_seq) begin
        j = 0;
        for (int k = 0; k < NGRP; k++) begin
          if (m_mask[k]) begin
            e_rn[k] = (cyc >= m_start + MIN_LOW + j * GAP);
            j++;
          end else begin
            e_rn[k] = 1'b1;
          end
        end
        t_done  = m_start + MIN_LOW + j * GAP;
        e_clken = (cyc >= t_done);
        e_busy  = (cyc < t_done);
        e_done  = (cyc == t_done);
        if (cyc == t_done) m_in_seq = 1'b0;
      end else begin
        e_rn = '1; e_clken = 1'b1; e_busy = 1'b0; e_done = 1'b0;
      end
    end
  endtask

  task automatic step(input logic r, input logic q, input logic [NGRP-1:0] m);
    RST = r; REQ = q; MASK = m;
    @(posedge CLK);
    cyc++;
    model(r, q, m);
    #1;
    check("rn",    32'(RN),    32'(e_rn));
    check("clken", 32'(CLKEN), 32'(e_clken));
    check("busy",  32'(BUSY),  32'(e_busy));
    check("done",  32'(DONE),  32'(e_done));
    check("inv_clken_rn", 32'(CLKEN & ~(&RN)), 32'd0);
    check("inv_done_busy_fall", 32'(DONE), 32'(prev_busy & ~BUSY));
    check("inv_done_width", 32'(DONE & prev_done), 32'd0);
    prev_busy = BUSY;
    prev_done = DONE;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  initial begin
    // Cold reset: RST held for 3 edges, then the full 4-group release.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
    idle_cycles(16);

    // Soft reset of groups 1 and 3, plus a REQ during BUSY at F0+5.
    step(1'b0, 1'b1, 4'b1010);
    idle_cycles(4);
    step(1'b0, 1'b1, 4'b0001);
    idle_cycles(8);

    // REQ with an empty mask while idle.
    step(1'b0, 1'b1, 4'b0000);
    idle_cycles(3);

    // Single top group.
    step(1'b0, 1'b1, 4'b1000);
    idle_cycles(10);

    // Reset mid-RELEASE: cold sequence, RST sampled at the edge after E7.
    step(1'b1, 1'b0, '0);
    idle_cycles(8);          // E0..E7
    step(1'b1, 1'b0, '0);
    idle_cycles(16);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic r, q;
      logic [NGRP-1:0] m;
      r = ($urandom_range(0, 149) == 0);
      q = ($urandom_range(0, 5) == 0);
      m = NGRP'($urandom);
      step(r, q, m);
    end
    idle_cycles(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
